// File: rtl/sum_collector.sv
// Adder-result collector: a DEPTH-entry FIFO of {carry, sum} results with a sticky drop flag.
// Running total/count statistics are built only when SUM_COLLECTOR_ACC_EN is defined.
module sum_collector #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_sum,
  input  logic        in_carry,
  input  logic        clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:0] out_data,
  output logic [4:0]  level,
  output logic [39:0] acc,
  output logic [15:0] count,
  output logic        overflow_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [32:0]   mem_q [DEPTH];
  logic          push, pop, drop;

  // A full FIFO still accepts a result when the head leaves in the same cycle.
  always_comb begin
    pop  = (level_q != 5'd0) && out_ready;
    push = in_valid && ((level_q < DEPTH_L) || pop);
    drop = in_valid && !push;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase

    ovf_d = ovf_q;
    if (clear) begin
      ovf_d = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: level gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_carry, in_sum};
    end
  end

  assign out_valid    = (level_q != 5'd0);
  assign out_data     = out_valid ? mem_q[rd_ptr_q] : 33'd0;
  assign level        = level_q;
  assign overflow_err = ovf_q;

`ifdef SUM_COLLECTOR_ACC_EN
  logic [39:0] acc_q, acc_d;
  logic [15:0] count_q, count_d;

  // Clear wins over a simultaneous push; the entry itself still enters the FIFO.
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    if (clear) begin
      acc_d   = '0;
      count_d = '0;
    end else if (push) begin
      acc_d = acc_q + {7'b0, in_carry, in_sum};
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign acc   = acc_q;
  assign count = count_q;
`else
  assign acc   = '0;
  assign count = '0;
`endif

endmodule

// File: tb/tb_sum_collector.sv
// Self-checking bench for sum_collector: queue-based reference model checked every cycle,
// plus directed literal checks. Expectations follow SUM_COLLECTOR_ACC_EN.
`timescale 1ns/1ps
module tb_sum_collector;
  localparam int DEPTH = 4;
`ifdef SUM_COLLECTOR_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_sum = '0;
  logic        in_carry = 1'b0;
  logic        clear = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [32:0] out_data;
  logic [4:0]  level;
  logic [39:0] acc;
  logic [15:0] count;
  logic        overflow_err;

  sum_collector #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_sum(in_sum),
    .in_carry(in_carry), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level), .acc(acc), .count(count),
    .overflow_err(overflow_err)
  );

  always #5 clock = ~clock;

  logic [32:0] mq[$];
  logic [39:0] acc_m = '0;
  logic [15:0] cnt_m = '0;
  logic        ovf_m = 1'b0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    acc_m = '0;
    cnt_m = '0;
    ovf_m = 1'b0;
  endtask

  // Reference behaviour: queue of results plus plain arithmetic statistics.
  task automatic model_step();
    bit do_pop, do_push;
    do_pop  = (mq.size() != 0) && out_ready;
    do_push = in_valid && ((mq.size() < DEPTH) || do_pop);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back({in_carry, in_sum});
    if (clear) begin
      acc_m = '0;
      cnt_m = '0;
      ovf_m = 1'b0;
    end else begin
      if (do_push && ACC_EN) begin
        acc_m = acc_m + {7'b0, in_carry, in_sum};
        if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      end
      if (in_valid && !do_push) ovf_m = 1'b1;
    end
  endtask

  task automatic compare_all();
    logic [32:0] head;
    head = (mq.size() != 0) ? mq[0] : 33'd0;
    chk("out_valid", out_valid, (mq.size() != 0));
    chk("level", level, mq.size());
    chk("out_data", out_data, head);
    chk("acc", acc, acc_m);
    chk("count", count, cnt_m);
    chk("overflow_err", overflow_err, ovf_m);
  endtask

  task automatic cyc(input bit iv, input logic [32:0] d, input bit rdy, input bit clr);
    in_valid  = iv;
    in_carry  = d[32];
    in_sum    = d[31:0];
    out_ready = rdy;
    clear     = clr;
    @(posedge clock);
    if (!reset) model_step();
    #1;
    compare_all();
    $display("t=%0t iv=%0d d=%09h rdy=%0d clr=%0d -> level=%0d out=%09h acc=%010h cnt=%0d ovf=%0d",
             $time, iv, d, rdy, clr, level, out_data, acc, count, overflow_err);
  endtask

  initial begin
    int pushed;
    int guard;
    bit rdy, iv;
    logic [32:0] val;

    #1 reset = 1'b1;
    model_reset();
    #1 compare_all();
    repeat (2) @(posedge clock);
    #1;
    compare_all();
    chk("reset_level", level, 5'd0);
    chk("reset_out_data", out_data, 33'd0);
    reset = 1'b0;

    // Ordered output and accumulation across a carry-out.
    cyc(1'b1, 33'h0_0000_0001, 1'b1, 1'b0);
    chk("first_out", out_data, 33'h0_0000_0001);
    cyc(1'b1, 33'h1_FFFF_FFFF, 1'b1, 1'b0);
    chk("second_out", out_data, 33'h1_FFFF_FFFF);
    chk("acc_two", acc, ACC_EN ? 40'h02_0000_0000 : 40'h0);
    chk("count_two", count, ACC_EN ? 16'd2 : 16'd0);
    cyc(1'b0, 33'd0, 1'b1, 1'b0);
    chk("drained", level, 5'd0);

    // Overfill with the consumer stalled: fifth result dropped.
    cyc(1'b0, 33'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) cyc(1'b1, 33'(i), 1'b0, 1'b0);
    chk("full_level", level, 5'd4);
    chk("ovf_set", overflow_err, 1'b1);
    chk("acc_excl_5th", acc, ACC_EN ? 40'd10 : 40'd0);
    chk("count_4", count, ACC_EN ? 16'd4 : 16'd0);

    // Push and pop together while full: no drop.
    cyc(1'b0, 33'd0, 1'b0, 1'b1);
    chk("ovf_cleared", overflow_err, 1'b0);
    chk("level_kept_on_clear", level, 5'd4);
    cyc(1'b1, 33'h0_0000_0006, 1'b1, 1'b0);
    chk("full_pushpop_level", level, 5'd4);
    chk("full_pushpop_ovf", overflow_err, 1'b0);
    chk("full_pushpop_head", out_data, 33'h0_0000_0002);
    repeat (4) cyc(1'b0, 33'd0, 1'b1, 1'b0);
    chk("drained2", level, 5'd0);

    // Push into empty with ready high: pop ignored.
    cyc(1'b1, 33'h1_2345_6789, 1'b1, 1'b0);
    chk("empty_pushpop_level", level, 5'd1);
    cyc(1'b0, 33'd0, 1'b1, 1'b0);

    // Clear with simultaneous push.
    cyc(1'b1, 33'h0_0000_0005, 1'b0, 1'b1);
    chk("clr_push_acc", acc, 40'd0);
    chk("clr_push_count", count, 16'd0);
    chk("clr_push_level", level, 5'd1);
    chk("clr_push_head", out_data, 33'h0_0000_0005);
    cyc(1'b0, 33'd0, 1'b1, 1'b0);

    // Twelve results with random back-pressure, wrapping pointers.
    cyc(1'b0, 33'd0, 1'b0, 1'b1);
    pushed = 0;
    guard = 0;
    while (pushed < 12 && guard < 500) begin
      guard++;
      rdy = 1'($urandom_range(0, 1));
      iv  = (mq.size() < DEPTH) || (rdy && mq.size() != 0);
      val = {1'($urandom_range(0, 1)), 32'($urandom)};
      if (iv) pushed++;
      cyc(iv, val, rdy, 1'b0);
    end
    chk("random_pushes_done", pushed, 12);
    repeat (DEPTH) cyc(1'b0, 33'd0, 1'b1, 1'b0);
    chk("random_count", count, ACC_EN ? 16'd12 : 16'd0);
    chk("random_ovf", overflow_err, 1'b0);
    chk("random_drained", level, 5'd0);

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) cyc(1'b1, 33'h1_0000_00A0 + 33'(i), 1'b0, 1'b0);
    chk("pre_reset_level", level, 5'd3);
    #2 reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_level", level, 5'd0);
    chk("async_acc", acc, 40'd0);
    in_valid = 1'b1;
    in_sum   = 32'hDEAD_BEEF;
    @(posedge clock);
    #1;
    compare_all();
    reset = 1'b0;
    cyc(1'b1, 33'h0_CAFE_0001, 1'b0, 1'b0);
    chk("post_reset_out", out_data, 33'h0_CAFE_0001);
    chk("post_reset_level", level, 5'd1);
    cyc(1'b0, 33'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sum_collector.md
SUM_COLLECTOR -- requirements
Module: sum_collector

Interface
REQ-001 Parameter: DEPTH, 4, FIFO entries; power of two, 2..16.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  adder result present this cycle; no backpressure upstream.
REQ-005 in_sum  input  32  32-bit adder sum.
REQ-006 in_carry  input  1  32-bit adder carry-out.
REQ-007 clear  input  1  synchronous clear of statistics (acc, count, overflow_err).
REQ-008 out_valid  output  1  FIFO head entry available.
REQ-009 out_ready  input  1  downstream accepts head entry.
REQ-010 out_data  output  33  {carry, sum} of head entry.
REQ-011 level  output  5  current FIFO occupancy, 0..DEPTH.
REQ-012 acc  output  40  running total of accepted 33-bit results.
REQ-013 count  output  16  number of accepted results.
REQ-014 overflow_err  output  1  sticky flag: result dropped because FIFO full.

Function
REQ-015 A push SHALL occur when in_valid=1 and (level<DEPTH, or level=DEPTH with a pop in the same cycle).
REQ-016 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-017 out_valid SHALL equal (level!=0); no fall-through: a push into an empty FIFO SHALL appear on out_data one cycle later.
REQ-018 Entries SHALL leave in push order; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-019 Simultaneous push and pop SHALL leave level unchanged, at any level including 0 (pop ignored when empty) and DEPTH.
REQ-020 Read/write pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-021 in_valid=1 when level=DEPTH and no pop SHALL drop the result, set overflow_err next cycle and leave FIFO, acc and count unchanged.
REQ-022 On each push, acc SHALL update next cycle to acc + {7'b0, in_carry, in_sum}, wrapping modulo 2^40.
REQ-023 On each push, count SHALL increment by one, saturating at 65535.
REQ-024 clear=1 SHALL set acc, count and overflow_err to 0 next cycle; clear has priority over a simultaneous push for statistics, but the pushed entry still enters the FIFO.
REQ-025 clear SHALL not affect FIFO contents, level or out_valid.
REQ-026 overflow_err SHALL remain 1 until clear or reset.

Reset
REQ-027 While reset=1: level=0, out_valid=0, acc=0, count=0, overflow_err=0, pointers=0; out_data SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard all FIFO contents immediately (asynchronously); in_valid during reset SHALL be ignored.
REQ-029 First push SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro SUM_COLLECTOR_ACC_EN defined: acc and count logic SHALL be built per REQ-022..REQ-024.
REQ-031 Macro SUM_COLLECTOR_ACC_EN undefined: acc and count ports SHALL remain but be tied to 0; FIFO and overflow_err behaviour unchanged.

Verification
REQ-032 Reset, push {0,32'h0000_0001}, then {1,32'hFFFF_FFFF}, out_ready=1 -> out_data 33'h0_0000_0001 then 33'h1_FFFF_FFFF in order; acc=40'h02_0000_0000, count=2.
REQ-033 out_ready=0, push DEPTH+1 results back-to-back -> level=4, overflow_err=1 after 5th, acc excludes 5th value, 5th never appears at output.
REQ-034 Level=4, in_valid=1 and out_ready=1 same cycle -> no drop, level stays 4, overflow_err stays 0.
REQ-035 Push 12 results with random out_ready -> output order matches input order across pointer wrap; count=12.
REQ-036 clear=1 with simultaneous push of 33'h0_0000_0005 -> acc=0, count=0, overflow_err=0, level increments, entry later seen at output.
REQ-037 Reset asserted with level=3 mid-stream -> out_valid=0, level=0, acc=0 immediately; next push after release appears one cycle later.
